sprite_index_fetch: RTL and testbench

- Pixel-pipeline stage that sits directly upstream of the 4-bit palette lookup.
- For each scan position from the VGA controller, it decides whether the position falls inside one 32x32 sprite (a tank).
- On a hit it fetches the 4-bit colour index from a synchronous sprite ROM and presents index plus sprite_on to the palette and the pixel mux.
- It also applies frame-latched position and flip, and a damage-flash blink driven by a frame counter.

---
 rtl/sprite_index_fetch.sv | 130 +++++++++++++
 tb/tb_sprite_index_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_index_fetch.sv
// Sprite hit test and colour-index fetch for one 32x32 tank sprite, feeding the palette stage.
// Three-clock pipeline from drawX/drawY to index/sprite_on, plus frame-latched position/flip and a damage blink.
module sprite_index_fetch #(
    parameter int          SPR_W           = 32,
    parameter int          SPR_H           = 32,
    parameter int          ADDR_W          = 10,
    parameter logic [3:0]  TRANSPARENT_IDX = 4'd9,
    parameter logic [5:0]  FLASH_FRAMES    = 6'd32
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              flip_x,
    input  logic              flip_y,
    input  logic              hit_pulse,
    input  logic [9:0]        drawX,
    input  logic [9:0]        drawY,
    input  logic              pix_valid,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        index,
    output logic              sprite_on,
    output logic              flashing
);

    localparam int XW = $clog2(SPR_W);

    typedef enum logic {
        IDLE,
        FLASH
    } flash_state_t;

    flash_state_t      flash_state;
    logic [5:0]        flash_cnt;
    logic [9:0]        sx_pos;
    logic [9:0]        sy_pos;
    logic              sflip_x;
    logic              sflip_y;
    logic              v1;
    logic              v2;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic [10:0]       cx;
    logic [10:0]       cy;
    logic              hit;
    logic              blank;
    logic [ADDR_W-1:0] addr_next;

    // Position and flip only move at frame boundaries so the sprite never tears.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            sx_pos  <= '0;
            sy_pos  <= '0;
            sflip_x <= 1'b0;
            sflip_y <= 1'b0;
        end else if (frame_start) begin
            sx_pos  <= pos_x;
            sy_pos  <= pos_y;
            sflip_x <= flip_x;
            sflip_y <= flip_y;
        end
    end

    // Bit 10 of dx/dy is the sign; an unsigned compare against the size rejects negatives too.
    always_comb begin
        dx        = {1'b0, drawX} - {1'b0, sx_pos};
        dy        = {1'b0, drawY} - {1'b0, sy_pos};
        hit       = pix_valid & ~dx[10] & (dx < 11'(SPR_W)) & ~dy[10] & (dy < 11'(SPR_H));
        cx        = sflip_x ? (11'(SPR_W - 1) - dx) : dx;
        cy        = sflip_y ? (11'(SPR_H - 1) - dy) : dy;
        addr_next = (ADDR_W'(cy) << XW) + ADDR_W'(cx);
        blank     = (flash_state == FLASH) & flash_cnt[1];
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            rom_addr  <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            index     <= 4'd0;
            sprite_on <= 1'b0;
        end else begin
            rom_addr  <= hit ? addr_next : '0;
            v1        <= hit;
            v2        <= v1;
            index     <= v2 ? rom_data : 4'd0;
            sprite_on <= v2 & (rom_data != TRANSPARENT_IDX) & ~blank;
        end
    end

    // A new hit always restarts the blink, even on the frame that would have ended it.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            flash_state <= IDLE;
            flash_cnt   <= 6'd0;
            flashing    <= 1'b0;
        end else begin
            case (flash_state)
                IDLE: begin
                    if (hit_pulse) begin
                        flash_state <= FLASH;
                        flash_cnt   <= FLASH_FRAMES;
                        flashing    <= 1'b1;
                    end
                end
                FLASH: begin
                    if (hit_pulse) begin
                        flash_cnt <= FLASH_FRAMES;
                    end else if (frame_start) begin
                        if (flash_cnt == 6'd1) begin
                            flash_state <= IDLE;
                            flash_cnt   <= 6'd0;
                            flashing    <= 1'b0;
                        end else begin
                            flash_cnt <= flash_cnt - 6'd1;
                        end
                    end
                end
                default: begin
                    flash_state <= IDLE;
                    flash_cnt   <= 6'd0;
                    flashing    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_index_fetch.sv
// Self-checking bench for sprite_index_fetch: directed scenarios plus randomized scanning
// compared against an integer-arithmetic model of the sprite rules.
module tb_sprite_index_fetch;

    logic       Clk;
    logic       Reset_n;
    logic       frame_start;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       flip_x;
    logic       flip_y;
    logic       hit_pulse;
    logic [9:0] drawX;
    logic [9:0] drawY;
    logic       pix_valid;
    logic [9:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] index;
    logic       sprite_on;
    logic       flashing;

    int tests  = 0;
    int failed = 0;

    logic [3:0] rom [1024];

    sprite_index_fetch dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .flip_x      (flip_x),
        .flip_y      (flip_y),
        .hit_pulse   (hit_pulse),
        .drawX       (drawX),
        .drawY       (drawY),
        .pix_valid   (pix_valid),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .index       (index),
        .sprite_on   (sprite_on),
        .flashing    (flashing)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= rom[rom_addr];

    // Reference model: per-pixel results are queued two deep and released with the ROM word.
    int         sh_x, sh_y, flash_left, a0, a1;
    bit         sh_fx, sh_fy, h0, h1;
    logic [9:0] exp_addr;
    logic [3:0] exp_index;
    logic       exp_on;
    logic       exp_flashing;

    always @(posedge Clk) begin : model
        int dxm, dym, cxm, cym;
        bit hitm, blank;
        if (!Reset_n) begin
            sh_x = 0; sh_y = 0; sh_fx = 0; sh_fy = 0;
            flash_left = 0; h0 = 0; h1 = 0; a0 = 0; a1 = 0;
            exp_addr = '0; exp_index = '0; exp_on = 1'b0; exp_flashing = 1'b0;
        end else begin
            blank     = (flash_left > 0) && ((flash_left % 4) >= 2);
            exp_index = h1 ? rom[a1] : 4'd0;
            exp_on    = h1 && (rom[a1] != 4'd9) && !blank;
            dxm  = int'(drawX) - sh_x;
            dym  = int'(drawY) - sh_y;
            hitm = pix_valid && dxm >= 0 && dxm < 32 && dym >= 0 && dym < 32;
            cxm  = sh_fx ? 31 - dxm : dxm;
            cym  = sh_fy ? 31 - dym : dym;
            h1 = h0; a1 = a0;
            h0 = hitm; a0 = hitm ? cym * 32 + cxm : 0;
            exp_addr = 10'(a0);
            if (hit_pulse) flash_left = 32;
            else if (frame_start && flash_left > 0) flash_left = flash_left - 1;
            exp_flashing = flash_left > 0;
            if (frame_start) begin
                sh_x = int'(pos_x); sh_y = int'(pos_y); sh_fx = flip_x; sh_fy = flip_y;
            end
        end
    end

    task automatic drive(input int x, input int y, input bit v, input bit fs = 1'b0, input bit hp = 1'b0);
        drawX       = 10'(x);
        drawY       = 10'(y);
        pix_valid   = v;
        frame_start = fs;
        hit_pulse   = hp;
        @(negedge Clk);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        tests += 4;
        if (rom_addr !== 10'd0) begin failed++; $display("[TB] FAIL reset_addr got %0d want 0", rom_addr); end
        if (index !== 4'd0) begin failed++; $display("[TB] FAIL reset_index got %0d want 0", index); end
        if (sprite_on !== 1'b0) begin failed++; $display("[TB] FAIL reset_on got %0b want 0", sprite_on); end
        if (flashing !== 1'b0) begin failed++; $display("[TB] FAIL reset_flash got %0b want 0", flashing); end
        Reset_n = 1'b1;
        drive(0, 0, 0);
    endtask

    task automatic test_basic();
        pos_x = 10'd100; pos_y = 10'd50; flip_x = 1'b0; flip_y = 1'b0;
        drive(0, 0, 0, 1'b1);
        drive(100, 50, 1);
        tests++;
        if (rom_addr !== 10'd0) begin failed++; $display("[TB] FAIL basic_addr got %0d want 0", rom_addr); end
        drive(0, 0, 0);
        drive(0, 0, 0);
        tests += 2;
        if (index !== 4'd1) begin failed++; $display("[TB] FAIL basic_index got %0d want 1", index); end
        if (sprite_on !== 1'b1) begin failed++; $display("[TB] FAIL basic_on got %0b want 1", sprite_on); end
        drive(99, 50, 1);
        tests++;
        if (rom_addr !== 10'd0) begin failed++; $display("[TB] FAIL left_edge_addr got %0d want 0", rom_addr); end
        drive(132, 50, 1);
        tests++;
        if (rom_addr !== 10'd0) begin failed++; $display("[TB] FAIL right_edge_addr got %0d want 0", rom_addr); end
        drive(0, 0, 0);
        tests += 2;
        if (sprite_on !== 1'b0) begin failed++; $display("[TB] FAIL left_edge_on got %0b want 0", sprite_on); end
        if (index !== 4'd0) begin failed++; $display("[TB] FAIL left_edge_index got %0d want 0", index); end
        drive(131, 81, 1);
        tests += 2;
        if (sprite_on !== 1'b0) begin failed++; $display("[TB] FAIL right_edge_on got %0b want 0", sprite_on); end
        if (rom_addr !== 10'd1023) begin failed++; $display("[TB] FAIL corner_addr got %0d want 1023", rom_addr); end
        drive(0, 0, 0);
        drive(0, 0, 0);
    endtask

    task automatic test_flip();
        flip_x = 1'b1; flip_y = 1'b1;
        drive(0, 0, 0, 1'b1);
        drive(100, 50, 1);
        tests++;
        if (rom_addr !== 10'd1023) begin failed++; $display("[TB] FAIL flip_addr got %0d want 1023", rom_addr); end
        pos_x = 10'd200; flip_x = 1'b0;
        drive(100, 50, 1);
        tests++;
        if (rom_addr !== 10'd1023) begin failed++; $display("[TB] FAIL shadow_hold_addr got %0d want 1023", rom_addr); end
        drive(101, 51, 1);
        tests++;
        if (rom_addr !== 10'd990) begin failed++; $display("[TB] FAIL flip_inner_addr got %0d want 990", rom_addr); end
        drive(0, 0, 0, 1'b1);
        drive(200, 50, 1);
        tests++;
        if (rom_addr !== 10'd992) begin failed++; $display("[TB] FAIL new_frame_addr got %0d want 992", rom_addr); end
        flip_y = 1'b0; pos_x = 10'd100;
        drive(0, 0, 0, 1'b1);
        drive(0, 0, 0);
        drive(0, 0, 0);
    endtask

    task automatic test_transparent();
        logic [3:0] w9;
        drive(105, 50, 1);
        tests++;
        if (rom_addr !== 10'd5) begin failed++; $display("[TB] FAIL transp_addr got %0d want 5", rom_addr); end
        drive(0, 0, 0);
        drive(0, 0, 0);
        tests += 2;
        if (index !== 4'd9) begin failed++; $display("[TB] FAIL transp_index got %0d want 9", index); end
        if (sprite_on !== 1'b0) begin failed++; $display("[TB] FAIL transp_on got %0b want 0", sprite_on); end
        pos_x = 10'd630;
        drive(0, 0, 0, 1'b1);
        drive(639, 50, 1);
        tests++;
        if (rom_addr !== 10'd9) begin failed++; $display("[TB] FAIL clip_addr got %0d want 9", rom_addr); end
        drive(0, 0, 0);
        drive(0, 0, 0);
        w9 = rom[9];
        tests += 2;
        if (index !== w9) begin failed++; $display("[TB] FAIL clip_index got %0d want %0d", index, w9); end
        if (sprite_on !== (w9 != 4'd9)) begin failed++; $display("[TB] FAIL clip_on got %0b want %0b", sprite_on, w9 != 4'd9); end
        pos_x = 10'd100;
        drive(0, 0, 0, 1'b1);
    endtask

    task automatic test_flash();
        bit want_on;
        pos_x = 10'd100; pos_y = 10'd50; flip_x = 1'b0; flip_y = 1'b0;
        drive(0, 0, 0, 1'b0, 1'b1);
        tests++;
        if (flashing !== 1'b1) begin failed++; $display("[TB] FAIL flash_start got %0b want 1", flashing); end
        for (int f = 1; f <= 32; f++) begin
            drive(0, 0, 0, 1'b1);
            drive(100, 50, 1);
            drive(0, 0, 0);
            drive(0, 0, 0);
            want_on = ((32 - f) % 4) < 2;
            tests += 2;
            if (sprite_on !== want_on) begin failed++; $display("[TB] FAIL flash_on frame %0d got %0b want %0b", f, sprite_on, want_on); end
            if (rom_addr !== exp_addr || index !== exp_index || sprite_on !== exp_on || flashing !== exp_flashing) begin
                failed++;
                $display("[TB] FAIL flash_model frame %0d addr/index/on/flash got %0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b",
                         f, rom_addr, index, sprite_on, flashing, exp_addr, exp_index, exp_on, exp_flashing);
            end
        end
        tests++;
        if (flashing !== 1'b0) begin failed++; $display("[TB] FAIL flash_end got %0b want 0", flashing); end
        drive(0, 0, 0, 1'b0, 1'b1);
        for (int f = 0; f < 27; f++) drive(0, 0, 0, 1'b1);
        drive(0, 0, 0, 1'b0, 1'b1);
        for (int f = 0; f < 31; f++) drive(0, 0, 0, 1'b1);
        tests++;
        if (flashing !== 1'b1) begin failed++; $display("[TB] FAIL flash_reload got %0b want 1", flashing); end
        drive(0, 0, 0, 1'b1);
        tests++;
        if (flashing !== 1'b0) begin failed++; $display("[TB] FAIL flash_reload_end got %0b want 0", flashing); end
    endtask

    task automatic test_random();
        int x, y, cpx, cpy;
        cpx = 100; cpy = 50;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(9) == 0) begin
                case ($urandom_range(3))
                    0: cpx = 600 + $urandom_range(39);
                    1: cpx = 640 + $urandom_range(383);
                    default: cpx = $urandom_range(600);
                endcase
                cpy = $urandom_range(470);
                pos_x = 10'(cpx); pos_y = 10'(cpy);
                flip_x = 1'($urandom); flip_y = 1'($urandom);
            end
            x = cpx - 3 + $urandom_range(38);
            y = cpy - 3 + $urandom_range(38);
            if (x < 0) x = 0;
            if (x > 639) x = 639;
            if (y < 0) y = 0;
            if (y > 479) y = 479;
            drive(x, y, $urandom_range(7) != 0, $urandom_range(29) == 0, $urandom_range(99) == 0);
            tests++;
            if (rom_addr !== exp_addr || index !== exp_index || sprite_on !== exp_on || flashing !== exp_flashing) begin
                failed++;
                $display("[TB] FAIL random cycle %0d addr/index/on/flash got %0d/%0d/%0b/%0b want %0d/%0d/%0b/%0b",
                         i, rom_addr, index, sprite_on, flashing, exp_addr, exp_index, exp_on, exp_flashing);
            end
        end
    endtask

    task automatic test_reset_mid();
        pos_x = 10'd100; pos_y = 10'd50; flip_x = 1'b0; flip_y = 1'b0;
        drive(0, 0, 0, 1'b1);
        drive(0, 0, 0, 1'b0, 1'b1);
        drive(100, 50, 1);
        drive(0, 0, 0);
        Reset_n = 1'b0;
        drive(0, 0, 0);
        tests += 3;
        if (index !== 4'd0) begin failed++; $display("[TB] FAIL midreset_index got %0d want 0", index); end
        if (sprite_on !== 1'b0) begin failed++; $display("[TB] FAIL midreset_on got %0b want 0", sprite_on); end
        if (flashing !== 1'b0) begin failed++; $display("[TB] FAIL midreset_flash got %0b want 0", flashing); end
        Reset_n = 1'b1;
        drive(0, 0, 0);
        drive(5, 3, 1);
        tests++;
        if (rom_addr !== 10'd101) begin failed++; $display("[TB] FAIL midreset_shadow_addr got %0d want 101", rom_addr); end
        drive(100, 50, 1);
        tests++;
        if (rom_addr !== 10'd0) begin failed++; $display("[TB] FAIL midreset_oldpos_addr got %0d want 0", rom_addr); end
        drive(0, 0, 0);
        drive(0, 0, 0);
        tests++;
        if (flashing !== 1'b0) begin failed++; $display("[TB] FAIL midreset_idle got %0b want 0", flashing); end
    endtask

    initial begin
        Reset_n = 1'b0; frame_start = 1'b0; hit_pulse = 1'b0; pix_valid = 1'b0;
        pos_x = '0; pos_y = '0; flip_x = 1'b0; flip_y = 1'b0; drawX = '0; drawY = '0;
        for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom);
        rom[0] = 4'd1;
        rom[5] = 4'd9;
        rom[990] = 4'd3;
        test_reset();
        test_basic();
        test_flip();
        test_transparent();
        test_flash();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
